// File: rtl/cic_pkg.sv
// Shared defaults and width helpers for the CIC decimator slice.
package cic_pkg;

   localparam int CIC_R = 16;
   localparam int CIC_N = 3;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int OUT_W = CIC_N * clog2(CIC_R) + 1;

   typedef logic [OUT_W-1:0] cic_word_t;

endpackage

// File: rtl/cic_decimator_if.sv
// Bitstream-in / decimated-sample-out bundle of the CIC decimator.
interface cic_decimator_if #(parameter int W = cic_pkg::OUT_W);

   logic         in_bit;
   logic         in_valid;
   logic [W-1:0] out_data;
   logic         out_valid;

   modport master (output in_bit, in_valid, input out_data, out_valid);
   modport slave  (input in_bit, in_valid, output out_data, out_valid);

endinterface

// File: rtl/cic_comb_stage.sv
// One comb section: differential delay of one decimated sample, modulo 2^W.
module cic_comb_stage
   import cic_pkg::*;
#(
   parameter int W = OUT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] dly;

   assign dout = din - dly;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  dly <= '0;
      else if (en) dly <= din;
   end

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator: 1-bit stream in, unsigned OUT_W-bit samples out every R accepted bits.
module cic_decimator #(
   parameter int R = cic_pkg::CIC_R,
   parameter int N = cic_pkg::CIC_N
) (
   input  logic           clk,
   input  logic           reset,
   cic_decimator_if.slave bus
);

   localparam int LR    = cic_pkg::clog2(R);
   localparam int OUT_W = N * LR + 1;

   logic [N-1:0][OUT_W-1:0] integ;
   logic [N:0][OUT_W-1:0]   comb_c;
   logic [LR-1:0]           dec_cnt;
   logic                    dec_tick;

   // Wrapping arithmetic is intentional: the comb differences cancel the overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         integ    <= '0;
         dec_cnt  <= '0;
         dec_tick <= 1'b0;
      end else begin
         dec_tick <= 1'b0;
         if (bus.in_valid) begin
            integ[0] <= integ[0] + OUT_W'(bus.in_bit);
            for (int k = 1; k < N; k++)
               integ[k] <= integ[k] + integ[k-1];
            dec_cnt  <= dec_cnt + 1'b1;
            dec_tick <= (dec_cnt == LR'(R - 1));
         end
      end
   end

   // Comb chain sees the integrator output before this edge's integrator update.
   assign comb_c[0] = integ[N-1];

   generate
      for (genvar k = 0; k < N; k++) begin : g_comb
         cic_comb_stage #(.W(OUT_W)) u_comb (
            .clk   (clk),
            .reset (reset),
            .en    (dec_tick),
            .din   (comb_c[k]),
            .dout  (comb_c[k+1])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         bus.out_valid <= dec_tick;
         if (dec_tick) bus.out_data <= comb_c[N];
      end
   end

endmodule

// File: doc/cic_decimator.md
# cic_decimator

Three-stage cascaded integrator-comb (CIC) decimator. It turns the 1-bit sigma-delta bitstream from the on-chip modulator interface into unsigned multi-bit samples at 1/R of the input sample rate. It sits directly upstream of the VGA display top, which consumes `out_data`/`out_valid` to plot the decimated waveform. The design uses no multipliers: it needs only adders, subtractors and a decimation counter.

## Interface
Parameters:
- `R`, default 16: decimation ratio. Must be a power of two, at least 2.
- `N`, default 3: number of integrator stages and number of comb stages.
- `OUT_W`, derived localparam = N*log2(R)+1, 13 at the defaults: width of all internal registers and of `out_data`.

Ports:
- `clk`  input  1: single system clock; all state changes on the rising edge.
- `reset`  input  1: asynchronous, active-low reset. Asserting it (low) immediately clears all state; it is released synchronously by the upstream reset synchronizer.
- `in_bit`  input  1: bitstream sample. 1 → +1, 0 → 0, zero-extended to OUT_W.
- `in_valid`  input  1: qualifies `in_bit` for the current cycle. Idle cycles are allowed anywhere.
- `out_data`  output  OUT_W: decimated sample, unsigned. Held between updates.
- `out_valid`  output  1: one-cycle strobe marking a new `out_data`.

## Operation
- Integrators `i[0..N-1]` are pipelined and update only when `in_valid`=1:
  - `i[0] <= i[0] + x`.
  - `i[k] <= i[k] + i[k-1]`, where `i[k-1]` is its pre-edge value.
  - All arithmetic is modulo 2^OUT_W. Overflow wraps silently; this is required for CIC correctness, so no saturation.
- Decimation counter `dec_cnt`, log2(R) bits:
  - Increments on each accepted sample.
  - When it wraps from R-1 to 0, it sets the one-cycle internal flag `dec_tick`.
- Combs, evaluated only on the cycle where `dec_tick`=1:
  - Combinational chain: `c[0] = i[N-1] - d[0]`, then `c[k] = c[k-1] - d[k]`, all modulo 2^OUT_W.
  - On that edge: `d[k] <= c[k-1]` (with `c[-1]` = `i[N-1]`), `out_data <= c[N-1]`, `out_valid <= 1`.
  - On every other edge: `out_valid <= 0` and `out_data` holds.
- If `in_valid` and `dec_tick` coincide, both updates happen in the same cycle. The comb reads `i[N-1]` before that edge's integrator update.
- Steady-state DC gain is R^N = 4096 at the defaults, which fits in OUT_W unsigned. No output scaling is applied.

## Timing
- Reset values (while `reset`=0): all `i`, `d`, `dec_cnt`, `dec_tick`, `out_data` = 0; `out_valid` = 0.
- Latency: the edge E that accepts the R-th sample of a window sets `dec_tick`. `out_data` and `out_valid` update at edge E+1.
- Throughput: exactly one `out_valid` per R accepted samples, independent of idle-cycle spacing.
- `out_valid` is never high on two consecutive cycles, since R ≥ 2.
- Settling: with a constant input, the 4th and every later output equal the steady-state value. The first 3 outputs are transient and unspecified.
- Reset mid-window: counter and all accumulators clear. The first output after release comes R accepted samples later. A `dec_tick` pending at the moment of reset is discarded.
- No back-pressure: the consumer must accept every strobe.

## Structure
- Package `cic_pkg`:
  - default R and N;
  - `function clog2`;
  - derived OUT_W;
  - `typedef logic [OUT_W-1:0] cic_word_t`.
- Sub-module `cic_comb_stage`: one delay register plus subtractor, with an enable. Instantiate it N times in a generate loop. Integrators stay inline in the top.
- Top module `cic_decimator`: counter, integrator chain, output register.

## Test plan
- Reset: hold `reset`=0 for 5 cycles with `in_valid`=1. Required: `out_valid`=0 and `out_data`=0 throughout, and no strobe within R-1 accepted samples after release.
- DC ones: `in_bit`=1 with `in_valid`=1 continuous for 200 outputs. Required: a strobe every 16 cycles, outputs from the 4th onward = 4096, and every strobe exactly 1 cycle wide.
- DC zeros and alternating 1,0: required outputs from the 4th onward are 0 and 2048 respectively.
- Gapped input: `in_valid` pseudo-random at about 40% duty with `in_bit`=1. Required: outputs from the 4th onward = 4096, and strobe count = accepted samples / 16.
- Wrap-around: 200 000 accepted ones, which overflows the integrators many times. Required: every output from the 4th onward is still 4096.
- Mid-window reset: pulse `reset` low for 1 cycle after 7 accepted samples of a window, then feed ones. Required:
  - no strobe until 16 accepted samples after release;
  - the output sequence matches the fresh-from-reset DC-ones sequence.
